regfile_wb_sched: RTL and testbench

- Write-back scheduler and scoreboard in front of the 32x32 register file.
- Shares the file's single write port between the in-order pipeline write-back and the multi-cycle M-unit (mul/div) results.
- Tracks which registers have an outstanding M-unit result and stalls decode on RAW/WAW hazards against them.
- Sits between the WB stage, the M-unit and reg_file's rd_we_i/rd_address_i/rd_data_i.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/wb_result_fifo.sv | 60 ++++++
 rtl/regfile_wb_sched.sv | 145 ++++++++++++++
 tb/tb_regfile_wb_sched.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back scheduler.
// Holds the address-width helper, the x0 constant and the write-source type.
package regfile_pkg;

  // Address width for a register file of n entries (never narrower than 1 bit).
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Default register count and its address width.
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = addr_w(NUM_REGS_DEF);

  // Architectural zero register; writes to it are dropped.
  localparam int REG_ZERO = 0;

  // Origin of the write currently presented to the register file.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_PIPE,
    WB_MD
  } wb_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small addr+data FIFO holding M-unit results until the write port is free.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_result_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 2,
  parameter  int AW    = 5,
  parameter  int DW    = 32,
  localparam int PW    = addr_w(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage: written on push only, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard in front of the 32x32 register file.
// Pipeline write-back always owns the single write port; M-unit results are
// buffered and drained in order when the pipeline is idle. Registers awaiting
// an M-unit result stall decode.
// Optional macro REGFILE_WB_BYPASS_EN: an M result accepted into an empty
// buffer while the pipeline is idle skips the buffer (1-cycle latency).
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter  int NUMBER_OF_REGISTERS = 32,
  parameter  int DATA_W              = 32,
  parameter  int MD_BUF_DEPTH        = 2,
  localparam int AW                  = addr_w(NUMBER_OF_REGISTERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_valid_i,
  input  logic [AW-1:0]     pipe_wb_addr_i,
  input  logic [DATA_W-1:0] pipe_wb_data_i,
  input  logic              md_valid_i,
  output logic              md_ready_o,
  input  logic [AW-1:0]     md_addr_i,
  input  logic [DATA_W-1:0] md_data_i,
  input  logic              md_issue_i,
  input  logic [AW-1:0]     md_issue_addr_i,
  input  logic              dec_valid_i,
  input  logic [AW-1:0]     dec_rs1_addr_i,
  input  logic [AW-1:0]     dec_rs2_addr_i,
  input  logic [AW-1:0]     dec_rd_addr_i,
  output logic              stall_o,
  output logic              rd_we_o,
  output logic [AW-1:0]     rd_address_o,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int            CW     = $clog2(MD_BUF_DEPTH + 1);
  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);

  logic                           md_accept;
  logic                           md_bypass;
  logic                           fifo_push;
  logic                           fifo_pop;
  logic [AW-1:0]                  fifo_head_addr;
  logic [DATA_W-1:0]              fifo_head_data;
  logic [CW-1:0]                  fifo_count;
  logic [CW-1:0]                  cnt_nxt;
  logic                           fifo_full;
  logic                           fifo_empty;
  wb_src_e                        wb_src_p1;
  logic [NUMBER_OF_REGISTERS-1:0] pending;

  assign md_accept = md_valid_i & md_ready_o;

`ifdef REGFILE_WB_BYPASS_EN
  assign md_bypass = md_accept & fifo_empty & ~pipe_wb_valid_i;
`else
  assign md_bypass = 1'b0;
`endif

  // Buffer head drains only when the pipeline leaves the port free.
  assign fifo_pop  = ~pipe_wb_valid_i & ~fifo_empty;
  assign fifo_push = md_accept & ~md_bypass & (~fifo_full | fifo_pop);

  wb_result_fifo #(
    .DEPTH (MD_BUF_DEPTH),
    .AW    (AW),
    .DW    (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_addr (md_addr_i),
    .push_data (md_data_i),
    .pop       (fifo_pop),
    .head_addr (fifo_head_addr),
    .head_data (fifo_head_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Occupancy after this edge, so ready never lags a fill.
  always_comb begin
    cnt_nxt = fifo_count;
    case ({fifo_push, fifo_pop})
      2'b10:   cnt_nxt = fifo_count + 1'b1;
      2'b01:   cnt_nxt = fifo_count - 1'b1;
      default: ;
    endcase
  end

  // Registered ready: low in reset, otherwise high while a slot remains.
  always_ff @(posedge clk) begin
    if (rst) md_ready_o <= 1'b0;
    else     md_ready_o <= (cnt_nxt < CW'(MD_BUF_DEPTH));
  end

  // Stage p1: write-port arbitration, pipeline first, then M result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we_o      <= 1'b0;
      rd_address_o <= '0;
      rd_data_o    <= '0;
      wb_src_p1    <= WB_NONE;
    end else if (pipe_wb_valid_i) begin
      rd_we_o      <= (pipe_wb_addr_i != ZERO_A);
      rd_address_o <= pipe_wb_addr_i;
      rd_data_o    <= pipe_wb_data_i;
      wb_src_p1    <= WB_PIPE;
    end else if (md_bypass) begin
      rd_we_o      <= (md_addr_i != ZERO_A);
      rd_address_o <= md_addr_i;
      rd_data_o    <= md_data_i;
      wb_src_p1    <= WB_MD;
    end else if (fifo_pop) begin
      rd_we_o      <= (fifo_head_addr != ZERO_A);
      rd_address_o <= fifo_head_addr;
      rd_data_o    <= fifo_head_data;
      wb_src_p1    <= WB_MD;
    end else begin
      rd_we_o      <= 1'b0;
      wb_src_p1    <= WB_NONE;
    end
  end

  // Scoreboard: clear when the M result is written, set on issue (set wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (rd_we_o && (wb_src_p1 == WB_MD))
        pending[rd_address_o] <= 1'b0;
      if (md_issue_i && (md_issue_addr_i != ZERO_A))
        pending[md_issue_addr_i] <= 1'b1;
    end
  end

  // Decode stalls on any hazard against an outstanding M result.
  assign stall_o = dec_valid_i &
                   ((pending[dec_rs1_addr_i] & (dec_rs1_addr_i != ZERO_A)) |
                    (pending[dec_rs2_addr_i] & (dec_rs2_addr_i != ZERO_A)) |
                    (pending[dec_rd_addr_i]  & (dec_rd_addr_i  != ZERO_A)) |
                    (md_issue_i & ~md_ready_o));

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios followed by random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_regfile_wb_sched;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
`ifdef REGFILE_WB_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wb_valid_i;
  logic [AW-1:0] pipe_wb_addr_i;
  logic [DW-1:0] pipe_wb_data_i;
  logic          md_valid_i;
  logic          md_ready_o;
  logic [AW-1:0] md_addr_i;
  logic [DW-1:0] md_data_i;
  logic          md_issue_i;
  logic [AW-1:0] md_issue_addr_i;
  logic          dec_valid_i;
  logic [AW-1:0] dec_rs1_addr_i;
  logic [AW-1:0] dec_rs2_addr_i;
  logic [AW-1:0] dec_rd_addr_i;
  logic          stall_o;
  logic          rd_we_o;
  logic [AW-1:0] rd_address_o;
  logic [DW-1:0] rd_data_o;

  always #5 clk = ~clk;

  regfile_wb_sched dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_wb_valid_i (pipe_wb_valid_i),
    .pipe_wb_addr_i  (pipe_wb_addr_i),
    .pipe_wb_data_i  (pipe_wb_data_i),
    .md_valid_i      (md_valid_i),
    .md_ready_o      (md_ready_o),
    .md_addr_i       (md_addr_i),
    .md_data_i       (md_data_i),
    .md_issue_i      (md_issue_i),
    .md_issue_addr_i (md_issue_addr_i),
    .dec_valid_i     (dec_valid_i),
    .dec_rs1_addr_i  (dec_rs1_addr_i),
    .dec_rs2_addr_i  (dec_rs2_addr_i),
    .dec_rd_addr_i   (dec_rd_addr_i),
    .stall_o         (stall_o),
    .rd_we_o         (rd_we_o),
    .rd_address_o    (rd_address_o),
    .rd_data_o       (rd_data_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: buffered M results as a queue, pending set as flags.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } res_t;

  res_t          mq[$];
  bit            pend[32];
  bit            m_we;
  bit            m_md;
  bit            m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic bit m_stall();
    if (!dec_valid_i) return 1'b0;
    if (dec_rs1_addr_i != 0 && pend[dec_rs1_addr_i]) return 1'b1;
    if (dec_rs2_addr_i != 0 && pend[dec_rs2_addr_i]) return 1'b1;
    if (dec_rd_addr_i  != 0 && pend[dec_rd_addr_i])  return 1'b1;
    return md_issue_i && !m_ready;
  endfunction

  // Model of one clock edge using the inputs currently applied.
  task automatic m_edge();
    bit   acc;
    res_t r;
    res_t h;
    acc = md_valid_i && m_ready;
    if (rst) begin
      mq.delete();
      foreach (pend[i]) pend[i] = 1'b0;
      m_ready = 1'b0;
      m_we    = 1'b0;
      m_md    = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      return;
    end
    if (pipe_wb_valid_i && pipe_wb_addr_i != 0)
      check_eq("pipe_to_pending", {31'd0, pend[pipe_wb_addr_i]}, 32'd0);
    if (m_we && m_md) pend[m_addr] = 1'b0;
    r.a = md_addr_i;
    r.d = md_data_i;
    if (pipe_wb_valid_i) begin
      m_we   = (pipe_wb_addr_i != 0);
      m_addr = pipe_wb_addr_i;
      m_data = pipe_wb_data_i;
      m_md   = 1'b0;
    end else begin
`ifdef REGFILE_WB_BYPASS_EN
      if (acc && mq.size() == 0) begin
        m_we   = (r.a != 0);
        m_addr = r.a;
        m_data = r.d;
        m_md   = 1'b1;
        acc    = 1'b0;
      end else
`endif
      if (mq.size() > 0) begin
        h      = mq.pop_front();
        m_we   = (h.a != 0);
        m_addr = h.a;
        m_data = h.d;
        m_md   = 1'b1;
      end else begin
        m_we = 1'b0;
        m_md = 1'b0;
      end
    end
    if (acc) mq.push_back(r);
    if (md_issue_i && md_issue_addr_i != 0) pend[md_issue_addr_i] = 1'b1;
    m_ready = (mq.size() < DEPTH);
  endtask

  // One cycle: check stall mid-cycle, clock, then check the write port.
  task automatic tick();
    #1 check_eq("stall_o", {31'd0, stall_o}, {31'd0, m_stall()});
    @(posedge clk);
    m_edge();
    #1;
    check_eq("rd_we_o", {31'd0, rd_we_o}, {31'd0, m_we});
    check_eq("md_ready_o", {31'd0, md_ready_o}, {31'd0, m_ready});
    if (m_we) begin
      check_eq("rd_address_o", {27'd0, rd_address_o}, {27'd0, m_addr});
      check_eq("rd_data_o", rd_data_o, m_data);
    end
  endtask

  task automatic idle();
    pipe_wb_valid_i = 1'b0;
    md_valid_i      = 1'b0;
    md_issue_i      = 1'b0;
    dec_valid_i     = 1'b0;
  endtask

  task automatic issue(input int rd);
    md_issue_i      = 1'b1;
    md_issue_addr_i = AW'(rd);
    tick();
    md_issue_i      = 1'b0;
  endtask

  // Two pipeline cycles while two M results arrive, leaving the buffer full.
  task automatic fill_two(input int a0, input int a1);
    for (int i = 0; i < 2; i++) begin
      pipe_wb_valid_i = 1'b1;
      pipe_wb_addr_i  = AW'(20 + i);
      pipe_wb_data_i  = 32'h2000 + i;
      md_valid_i      = 1'b1;
      md_addr_i       = AW'((i == 0) ? a0 : a1);
      md_data_i       = 32'h500 + i;
      tick();
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   iq[$];
    bit   acc;
    int   rd;

    rst = 1'b1;
    idle();
    pipe_wb_addr_i = '0; pipe_wb_data_i = '0;
    md_addr_i = '0; md_data_i = '0; md_issue_addr_i = '0;
    dec_rs1_addr_i = '0; dec_rs2_addr_i = '0; dec_rd_addr_i = '0;

    // Reset then idle
    tick();
    tick();
    check_eq("reset_we", {31'd0, rd_we_o}, 32'd0);
    check_eq("reset_ready", {31'd0, md_ready_o}, 32'd0);
    check_eq("reset_addr", {27'd0, rd_address_o}, 32'd0);
    check_eq("reset_data", rd_data_o, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("ready_after_reset", {31'd0, md_ready_o}, 32'd1);

    // Pipeline write, then a write to x0
    pipe_wb_valid_i = 1'b1; pipe_wb_addr_i = 5'd5; pipe_wb_data_i = 32'hDEADBEEF;
    tick();
    check_eq("pipe_we", {31'd0, rd_we_o}, 32'd1);
    check_eq("pipe_addr", {27'd0, rd_address_o}, 32'd5);
    check_eq("pipe_data", rd_data_o, 32'hDEADBEEF);
    pipe_wb_addr_i = 5'd0;
    tick();
    check_eq("pipe_x0_we", {31'd0, rd_we_o}, 32'd0);
    idle();

    // Scoreboard stall on x7 and M-result latency
    issue(7);
    dec_valid_i = 1'b1; dec_rs1_addr_i = 5'd1; dec_rs2_addr_i = 5'd7; dec_rd_addr_i = 5'd2;
    #1 check_eq("stall_rs2", {31'd0, stall_o}, 32'd1);
    md_valid_i = 1'b1; md_addr_i = 5'd7; md_data_i = 32'h42;
    tick();
    md_valid_i = 1'b0;
    lat = 1;
    while (!(rd_we_o && rd_address_o == 5'd7) && lat < 6) begin
      tick();
      lat++;
    end
    check_eq("md_latency", lat, EXP_LAT);
    check_eq("md_x7_data", rd_data_o, 32'h42);
    tick();
    check_eq("stall_after_write", {31'd0, stall_o}, 32'd0);
    idle();

    // Contention: pipeline busy 4 cycles while x3 then x4 arrive
    issue(3);
    issue(4);
    for (int i = 0; i < 4; i++) begin
      pipe_wb_valid_i = 1'b1;
      pipe_wb_addr_i  = AW'(10 + i);
      pipe_wb_data_i  = 32'h1000 + i;
      md_valid_i      = (i < 2);
      md_addr_i       = (i == 0) ? 5'd3 : 5'd4;
      md_data_i       = (i == 0) ? 32'h33 : 32'h44;
      tick();
      check_eq("cont_pipe_addr", {27'd0, rd_address_o}, 10 + i);
      if (i == 1) check_eq("cont_ready_full", {31'd0, md_ready_o}, 32'd0);
    end
    idle();
    tick();
    check_eq("cont_first_md", {27'd0, rd_address_o}, 32'd3);
    check_eq("cont_first_data", rd_data_o, 32'h33);
    tick();
    check_eq("cont_second_md", {27'd0, rd_address_o}, 32'd4);
    check_eq("cont_second_data", rd_data_o, 32'h44);
    tick();
    check_eq("cont_drained", {31'd0, rd_we_o}, 32'd0);

    // Full buffer draining while another result is offered
    issue(8);
    issue(9);
    issue(10);
    fill_two(8, 9);
    md_valid_i = 1'b1; md_addr_i = 5'd10; md_data_i = 32'hAA;
    tick();
    check_eq("full_pop_x8", {27'd0, rd_address_o}, 32'd8);
    lat = 0;
    while (!md_ready_o && lat < 4) begin
      tick();
      lat++;
    end
    tick();
    md_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("full_x10_cleared", {31'd0, pend[10]}, 32'd0);

    // Reset with two buffered results and x3/x4 pending
    issue(3);
    issue(4);
    fill_two(3, 4);
    check_eq("mid_ready_full", {31'd0, md_ready_o}, 32'd0);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_we", {31'd0, rd_we_o}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check_eq("mid_after_we", {31'd0, rd_we_o}, 32'd0);
    dec_valid_i = 1'b1; dec_rs1_addr_i = 5'd3; dec_rs2_addr_i = 5'd4; dec_rd_addr_i = 5'd3;
    #1 check_eq("mid_stall", {31'd0, stall_o}, 32'd0);
    tick();
    idle();

    // Random traffic; M results return in issue order
    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(0, 299) == 0);
      pipe_wb_valid_i = ($urandom_range(0, 2) == 0);
      pipe_wb_addr_i  = AW'($urandom);
      if (pend[pipe_wb_addr_i]) pipe_wb_addr_i = '0;
      pipe_wb_data_i  = $urandom;
      md_issue_i      = 1'b0;
      rd              = $urandom_range(0, 31);
      if (iq.size() < 3 && $urandom_range(0, 3) == 0 && !pend[rd]) begin
        md_issue_i      = 1'b1;
        md_issue_addr_i = AW'(rd);
      end
      md_valid_i = (iq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (iq.size() > 0) md_addr_i = AW'(iq[0]);
      md_data_i      = $urandom;
      dec_valid_i    = ($urandom_range(0, 1) == 1);
      dec_rs1_addr_i = AW'($urandom);
      dec_rs2_addr_i = AW'($urandom);
      dec_rd_addr_i  = AW'($urandom);
      acc = md_valid_i && m_ready && !rst;
      tick();
      if (rst) begin
        iq.delete();
      end else begin
        if (acc) void'(iq.pop_front());
        if (md_issue_i) iq.push_back(rd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
